// File: rtl/lpif_dstrm_credit_ctrl_if.sv
// Downstream beat handshake between the user logic and the LPIF credit controller.
// The user side (master) requests beats and returns credits; the controller (slave) grants beats.
interface lpif_dstrm_credit_ctrl_if;
  logic       dstrm_req;
  logic [1:0] credit_rtn;
  logic       dstrm_grant;

  modport master (
    output dstrm_req,
    output credit_rtn,
    input  dstrm_grant
  );

  modport slave (
    input  dstrm_req,
    input  credit_rtn,
    output dstrm_grant
  );
endinterface

// File: rtl/lpif_dstrm_credit_ctrl.sv
// LPIF downstream credit controller: OFFLINE/LOAD/ACTIVE/DRAIN link FSM with a saturating credit pool.
// Optional feature macro LPIF_CREDIT_OVF_CHECK_EN adds a sticky credit-overflow check against the pool size.
module lpif_dstrm_credit_ctrl (
  input  logic                          clk_wr,
  input  logic                          rst_wr,
  input  logic                          tx_online,
  input  logic                          rx_online,
  input  logic [7:0]                    init_downstream_credit,
  input  logic [15:0]                   drain_timeout,
  lpif_dstrm_credit_ctrl_if.slave       dstrm,
  output logic [7:0]                    credit_count,
  output logic [1:0]                    link_state,
  output logic                          credit_ovf_err,
  output logic                          drain_tmo_err,
  output logic [31:0]                   debug_status
);

  typedef enum logic [1:0] {
    OFFLINE = 2'd0,
    LOAD    = 2'd1,
    ACTIVE  = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] timer;
  logic        grant;
  logic        rtn_ok;
  logic [1:0]  rtn_eff;
  logic [8:0]  sum9;
  logic [15:0] timer_nxt;
  logic        tmo_hit;

  function automatic logic [7:0] sat_u8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  // Grant is combinational and is withheld on the cycle the link starts to leave ACTIVE.
  always_comb begin
    rtn_ok    = (state == ACTIVE) || (state == DRAIN);
    rtn_eff   = rtn_ok ? dstrm.credit_rtn : 2'd0;
    grant     = !rst_wr && (state == ACTIVE) && tx_online && rx_online &&
                dstrm.dstrm_req && (credit_count != 8'd0);
    sum9      = {1'b0, credit_count} + {7'd0, rtn_eff} - {8'd0, grant};
    timer_nxt = timer + 16'd1;
    tmo_hit   = (drain_timeout != 16'd0) && (timer_nxt == drain_timeout);
  end

  assign dstrm.dstrm_grant = grant;
  assign link_state        = state;

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state         <= OFFLINE;
      credit_count  <= 8'd0;
      timer         <= 16'd0;
      drain_tmo_err <= 1'b0;
    end else begin
      case (state)
        OFFLINE: begin
          credit_count <= 8'd0;
          if (tx_online && rx_online) state <= LOAD;
        end
        LOAD: begin
          if (!rx_online) begin
            state        <= OFFLINE;
            credit_count <= 8'd0;
          end else begin
            state        <= ACTIVE;
            credit_count <= init_downstream_credit;
          end
        end
        ACTIVE: begin
          if (!rx_online) begin
            state        <= OFFLINE;
            credit_count <= 8'd0;
          end else begin
            credit_count <= sat_u8(sum9);
            if (!tx_online) begin
              state <= DRAIN;
              timer <= 16'd0;
            end
          end
        end
        DRAIN: begin
          // A full pool means every outstanding beat has been returned; that wins over a timeout.
          if (!rx_online || (credit_count == init_downstream_credit)) begin
            state        <= OFFLINE;
            credit_count <= 8'd0;
          end else if (tmo_hit) begin
            state         <= OFFLINE;
            credit_count  <= 8'd0;
            drain_tmo_err <= 1'b1;
          end else begin
            credit_count <= sat_u8(sum9);
            timer        <= timer_nxt;
          end
        end
        default: begin
          state        <= OFFLINE;
          credit_count <= 8'd0;
        end
      endcase
    end
  end

`ifdef LPIF_CREDIT_OVF_CHECK_EN
  logic ovf_err_q;

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      ovf_err_q <= 1'b0;
    end else if (rtn_ok && rx_online && (sum9 > {1'b0, init_downstream_credit})) begin
      ovf_err_q <= 1'b1;
    end
  end

  assign credit_ovf_err = ovf_err_q;
`else
  assign credit_ovf_err = 1'b0;
`endif

  assign debug_status = {link_state, credit_ovf_err, drain_tmo_err, 4'h0,
                         init_downstream_credit, 8'h00, credit_count};

endmodule

// File: tb/tb_lpif_dstrm_credit_ctrl.sv
// Scoreboard bench for lpif_dstrm_credit_ctrl: per-cycle expected {grant, link_state, credit_count}
// is queued as stimulus is applied and compared once the clock edge has taken effect.
module tb_lpif_dstrm_credit_ctrl;

`ifdef LPIF_CREDIT_OVF_CHECK_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic        clk_wr = 1'b0;
  logic        rst_wr = 1'b1;
  logic        tx_online = 1'b0;
  logic        rx_online = 1'b0;
  logic [7:0]  init_downstream_credit = 8'd4;
  logic [15:0] drain_timeout = 16'd0;
  logic [7:0]  credit_count;
  logic [1:0]  link_state;
  logic        credit_ovf_err;
  logic        drain_tmo_err;
  logic [31:0] debug_status;

  lpif_dstrm_credit_ctrl_if ub ();

  lpif_dstrm_credit_ctrl dut (
    .clk_wr                 (clk_wr),
    .rst_wr                 (rst_wr),
    .tx_online              (tx_online),
    .rx_online              (rx_online),
    .init_downstream_credit (init_downstream_credit),
    .drain_timeout          (drain_timeout),
    .dstrm                  (ub.slave),
    .credit_count           (credit_count),
    .link_state             (link_state),
    .credit_ovf_err         (credit_ovf_err),
    .drain_tmo_err          (drain_tmo_err),
    .debug_status           (debug_status)
  );

  always #5 clk_wr = ~clk_wr;

  logic [10:0] q[$];
  logic [10:0] e;
  logic        g_s;
  int          total = 0;
  int          bad = 0;

  // stim = {req, rtn[1:0], tx, rx}; grant is sampled mid-cycle, before the edge it affects.
  task automatic drive(input logic [4:0] stim);
    @(negedge clk_wr);
    ub.dstrm_req  = stim[4];
    ub.credit_rtn = stim[3:2];
    tx_online     = stim[1];
    rx_online     = stim[0];
    #1 g_s = ub.dstrm_grant;
  endtask

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] stim [2] = '{5'b1_11_11, 5'b1_11_11};
    rst_wr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(stim[i]);
      q.push_back({1'b0, 2'd0, 8'd0});
      tick();
      e = q.pop_front();
      total++;
      if ({g_s, link_state, credit_count} !== e) begin
        bad++;
        $display("FAIL reset[%0d] got=%h want=%h", i, {g_s, link_state, credit_count}, e);
      end
    end
    total++;
    if (debug_status !== 32'h0004_0000) begin
      bad++;
      $display("FAIL reset_debug got=%h want=%h", debug_status, 32'h0004_0000);
    end
    total++;
    if ({credit_ovf_err, drain_tmo_err} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00", {credit_ovf_err, drain_tmo_err});
    end
    rst_wr = 1'b0;
  endtask

  task automatic test_load_grants();
    logic [4:0]  stim [8] = '{5'b1_10_11, 5'b1_11_11, 5'b1_00_11, 5'b1_00_11,
                              5'b1_00_11, 5'b1_00_11, 5'b1_00_11, 5'b1_00_11};
    logic [10:0] expv [8] = '{{1'b0, 2'd1, 8'd0}, {1'b0, 2'd2, 8'd4}, {1'b1, 2'd2, 8'd3},
                              {1'b1, 2'd2, 8'd2}, {1'b1, 2'd2, 8'd1}, {1'b1, 2'd2, 8'd0},
                              {1'b0, 2'd2, 8'd0}, {1'b0, 2'd2, 8'd0}};
    init_downstream_credit = 8'd4;
    for (int i = 0; i < 8; i++) begin
      drive(stim[i]);
      q.push_back(expv[i]);
      tick();
      e = q.pop_front();
      total++;
      if ({g_s, link_state, credit_count} !== e) begin
        bad++;
        $display("FAIL load_grants[%0d] got=%h want=%h", i, {g_s, link_state, credit_count}, e);
      end
    end
  endtask

  task automatic test_grant_rtn_net();
    logic [4:0]  stim [5] = '{5'b1_01_11, 5'b1_01_11, 5'b1_01_11, 5'b0_11_11, 5'b1_00_11};
    logic [10:0] expv [5] = '{{1'b0, 2'd2, 8'd1}, {1'b1, 2'd2, 8'd1}, {1'b1, 2'd2, 8'd1},
                              {1'b0, 2'd2, 8'd4}, {1'b1, 2'd2, 8'd3}};
    for (int i = 0; i < 5; i++) begin
      drive(stim[i]);
      q.push_back(expv[i]);
      tick();
      e = q.pop_front();
      total++;
      if ({g_s, link_state, credit_count} !== e) begin
        bad++;
        $display("FAIL grant_rtn_net[%0d] got=%h want=%h", i, {g_s, link_state, credit_count}, e);
      end
    end
  endtask

  task automatic test_rx_drop();
    logic [4:0]  stim [2] = '{5'b1_00_10, 5'b1_11_10};
    logic [10:0] expv [2] = '{{1'b0, 2'd0, 8'd0}, {1'b0, 2'd0, 8'd0}};
    for (int i = 0; i < 2; i++) begin
      drive(stim[i]);
      q.push_back(expv[i]);
      tick();
      e = q.pop_front();
      total++;
      if ({g_s, link_state, credit_count} !== e) begin
        bad++;
        $display("FAIL rx_drop[%0d] got=%h want=%h", i, {g_s, link_state, credit_count}, e);
      end
    end
    total++;
    if (debug_status !== 32'h0004_0000) begin
      bad++;
      $display("FAIL rx_drop_debug got=%h want=%h", debug_status, 32'h0004_0000);
    end
  endtask

  task automatic test_drain_exit();
    logic [4:0]  stim [8] = '{5'b0_00_11, 5'b0_00_11, 5'b1_00_11, 5'b1_00_11,
                              5'b1_00_11, 5'b1_00_01, 5'b1_11_01, 5'b0_00_01};
    logic [10:0] expv [8] = '{{1'b0, 2'd1, 8'd0}, {1'b0, 2'd2, 8'd8}, {1'b1, 2'd2, 8'd7},
                              {1'b1, 2'd2, 8'd6}, {1'b1, 2'd2, 8'd5}, {1'b0, 2'd3, 8'd5},
                              {1'b0, 2'd3, 8'd8}, {1'b0, 2'd0, 8'd0}};
    init_downstream_credit = 8'd8;
    drain_timeout          = 16'd0;
    for (int i = 0; i < 8; i++) begin
      drive(stim[i]);
      q.push_back(expv[i]);
      tick();
      e = q.pop_front();
      total++;
      if ({g_s, link_state, credit_count} !== e) begin
        bad++;
        $display("FAIL drain_exit[%0d] got=%h want=%h", i, {g_s, link_state, credit_count}, e);
      end
    end
    total++;
    if ({credit_ovf_err, drain_tmo_err} !== 2'b00) begin
      bad++;
      $display("FAIL drain_exit_flags got=%b want=00", {credit_ovf_err, drain_tmo_err});
    end
  endtask

  task automatic test_drain_timeout();
    logic [4:0]  stim [13];
    logic [10:0] expv [13];
    init_downstream_credit = 8'd8;
    drain_timeout          = 16'd10;
    stim[0] = 5'b0_00_11; expv[0] = {1'b0, 2'd1, 8'd0};
    stim[1] = 5'b0_00_11; expv[1] = {1'b0, 2'd2, 8'd8};
    stim[2] = 5'b1_00_11; expv[2] = {1'b1, 2'd2, 8'd7};
    for (int i = 3; i < 13; i++) begin
      stim[i] = 5'b0_00_01;
      expv[i] = {1'b0, 2'd3, 8'd7};
    end
    for (int i = 0; i < 13; i++) begin
      drive(stim[i]);
      q.push_back(expv[i]);
      tick();
      e = q.pop_front();
      total++;
      if ({g_s, link_state, credit_count} !== e) begin
        bad++;
        $display("FAIL drain_tmo[%0d] got=%h want=%h", i, {g_s, link_state, credit_count}, e);
      end
    end
    total++;
    if (drain_tmo_err !== 1'b0) begin
      bad++;
      $display("FAIL drain_tmo_early got=%b want=0", drain_tmo_err);
    end
    drive(5'b0_00_01);
    q.push_back({1'b0, 2'd0, 8'd0});
    tick();
    e = q.pop_front();
    total++;
    if ({g_s, link_state, credit_count, drain_tmo_err} !== {e, 1'b1}) begin
      bad++;
      $display("FAIL drain_tmo_fire got=%h want=%h", {g_s, link_state, credit_count, drain_tmo_err}, {e, 1'b1});
    end
    drive(5'b0_00_11);
    q.push_back({1'b0, 2'd1, 8'd0});
    tick();
    e = q.pop_front();
    total++;
    if ({g_s, link_state, credit_count, drain_tmo_err} !== {e, 1'b1}) begin
      bad++;
      $display("FAIL drain_tmo_sticky got=%h want=%h", {g_s, link_state, credit_count, drain_tmo_err}, {e, 1'b1});
    end
  endtask

  task automatic test_reset_mid_active();
    init_downstream_credit = 8'd4;
    drain_timeout          = 16'd0;
    drive(5'b0_00_11);
    q.push_back({1'b0, 2'd2, 8'd4});
    tick();
    e = q.pop_front();
    total++;
    if ({g_s, link_state, credit_count} !== e) begin
      bad++;
      $display("FAIL reset_mid_setup got=%h want=%h", {g_s, link_state, credit_count}, e);
    end
    rst_wr = 1'b1;
    drive(5'b1_01_11);
    q.push_back({1'b0, 2'd0, 8'd0});
    tick();
    e = q.pop_front();
    total++;
    if ({g_s, link_state, credit_count} !== e) begin
      bad++;
      $display("FAIL reset_mid_abort got=%h want=%h", {g_s, link_state, credit_count}, e);
    end
    total++;
    if ({credit_ovf_err, drain_tmo_err} !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_flags got=%b want=00", {credit_ovf_err, drain_tmo_err});
    end
    rst_wr = 1'b0;
  endtask

  task automatic test_overflow_sat();
    logic [4:0]  stim [3] = '{5'b0_00_11, 5'b0_00_11, 5'b0_10_11};
    logic [10:0] expv [3] = '{{1'b0, 2'd1, 8'd0}, {1'b0, 2'd2, 8'd4}, {1'b0, 2'd2, 8'd6}};
    int          cnt;
    init_downstream_credit = 8'd4;
    for (int i = 0; i < 3; i++) begin
      drive(stim[i]);
      q.push_back(expv[i]);
      tick();
      e = q.pop_front();
      total++;
      if ({g_s, link_state, credit_count} !== e) begin
        bad++;
        $display("FAIL ovf[%0d] got=%h want=%h", i, {g_s, link_state, credit_count}, e);
      end
    end
    total++;
    if (credit_ovf_err !== EXP_OVF) begin
      bad++;
      $display("FAIL ovf_flag got=%b want=%b", credit_ovf_err, EXP_OVF);
    end
    cnt = 6;
    for (int i = 0; i < 90; i++) begin
      cnt = (cnt + 3 > 255) ? 255 : cnt + 3;
      drive(5'b0_11_11);
      q.push_back({1'b0, 2'd2, 8'(cnt)});
      tick();
    end
    for (int i = 0; i < 90; i++) begin
      e = q.pop_front();
      if (i == 89) begin
        total++;
        if ({1'b0, link_state, credit_count} !== e) begin
          bad++;
          $display("FAIL sat_255 got=%h want=%h", {1'b0, link_state, credit_count}, e);
        end
      end
    end
    total++;
    if (debug_status !== {2'd2, EXP_OVF, 1'b0, 4'h0, 8'h04, 8'h00, 8'hFF}) begin
      bad++;
      $display("FAIL sat_debug got=%h want=%h", debug_status,
               {2'd2, EXP_OVF, 1'b0, 4'h0, 8'h04, 8'h00, 8'hFF});
    end
  endtask

  initial begin
    ub.dstrm_req  = 1'b0;
    ub.credit_rtn = 2'd0;
    test_reset();
    test_load_grants();
    test_grant_rtn_net();
    test_rx_drop();
    test_drain_exit();
    test_drain_timeout();
    test_reset_mid_active();
    test_overflow_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
